pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and pipeline-control unit for the five-stage MIPS pipeline. It reads the register and control fields held in the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It drives the write-enable, flush and bubble controls back into those registers, plus the EX-stage forwarding selects. It covers load-use stalls, taken-branch flushes and a multi-cycle multiply/divide (MDU) stall sequenced by a small state machine. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MDU_LAT, 3, total EX-stage occupancy of an MDU op in cycles; legal range 1..15
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID (IF/ID output)
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_rs, ex_rt, ex_rd  in  5 each  register fields of the instruction in EX (ID/EX output)
- ex_mem_read  in  1  EX instruction is a load
- ex_mdu_start  in  1  EX instruction is a mul/div
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_rd, mem_reg_write  in  5, 1  destination and write flag in EX/MEM output
- wb_rd, wb_reg_write  in  5, 1  destination and write flag in MEM/WB output
- pc_we, ifid_we, idex_we  out  1 each  register write enables (1 = advance)
- ifid_flush, idex_flush  out  1 each  load NOP into the register on this edge
- exmem_bubble  out  1  load NOP into EX/MEM (EX result not yet valid)
- fwd_a, fwd_b  out  2 each  ALU operand select for ex_rs / ex_rt: 00 regfile, 10 EX/MEM, 01 MEM/WB
- mdu_busy  out  1  high while the state is MDU_BUSY
- stall_count  out  16  count of cycles with pc_we=0, saturating

## Operation
- States: RUN, MDU_BUSY, MDU_DONE. A 4-bit counter cnt is used by MDU_BUSY.
- MDU entry: state RUN, ex_mdu_start=1 and MDU_LAT>1.
  - The entry cycle is an MDU stall cycle.
  - cnt <= MDU_LAT-2.
  - Next state is MDU_DONE if MDU_LAT==2, otherwise MDU_BUSY.
- MDU_LAT==1: ex_mdu_start causes no stall and no state change.
- MDU_BUSY: every cycle is an MDU stall cycle. cnt decrements each cycle; when cnt==1 the next state is MDU_DONE.
- MDU_DONE: no MDU stall; ex_mdu_start is ignored (the op is still in EX and now advances). Next state is RUN.
- Per-cycle control priority, highest first; unlisted outputs take defaults (we=1, flush=0, bubble=0):
  1. MDU stall cycle: pc_we=ifid_we=idex_we=0, exmem_bubble=1.
  2. ex_branch_taken=1: pc_we=1, ifid_flush=1, idex_flush=1.
  3. Load-use: ex_mem_read=1, ex_rd!=0, and either ex_rd==id_rs or (id_uses_rt and ex_rd==id_rt). Then pc_we=ifid_we=0, idex_flush=1.
- ex_branch_taken is ignored whenever an MDU stall cycle is active.
- Forwarding, computed every cycle regardless of state; fwd_b uses the same rules with ex_rt:
  - fwd_a=10 if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs.
  - Otherwise fwd_a=01 if wb_reg_write, wb_rd!=0 and wb_rd==ex_rs.
  - Otherwise fwd_a=00.
- The EX/MEM match takes precedence when both EX/MEM and MEM/WB match.
- Register 0 never causes a stall or a forward.
- stall_count increments on each clock edge where pc_we=0. It holds at 16'hFFFF once reached.

## Timing
- Reset (rst_n=0, asynchronous): state=RUN, cnt=0, stall_count=0, mdu_busy=0.
- Stall, flush and forward outputs are combinational from the current state and inputs. No added latency: they act on the same edge that would otherwise advance the registers.
- Load-use stall lasts exactly 1 cycle. On the next edge the load moves to MEM and the comparison clears.
- An MDU op holds the front end for MDU_LAT-1 cycles and advances on cycle MDU_LAT.
- mdu_busy is registered state: it is high from the cycle after entry through the last MDU_BUSY cycle.
- Reset asserted mid-MDU returns to RUN immediately; stalls release asynchronously.
- Load-use and taken branch in the same cycle: the flush wins and no stall is counted.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 -> for one cycle pc_we=0, ifid_we=0, idex_flush=1; stall_count goes 0->1.
- Forwarding: mem_rd=9 and wb_rd=9, both writing, ex_rs=9 -> fwd_a=10; with mem_reg_write=0 -> fwd_a=01; with ex_rs=0 -> fwd_a=00.
- MDU with MDU_LAT=4: ex_mdu_start held high -> stall in 3 consecutive cycles (entry, BUSY, BUSY) with exmem_bubble=1; MDU_DONE cycle has no stall; back to RUN; stall_count=3.
- Branch during a load-use condition: ex_branch_taken=1 -> pc_we=1, ifid_flush=1, idex_flush=1; stall_count unchanged.
- rst_n pulsed low during MDU_BUSY -> state RUN, pc_we=1 and mdu_busy=0 before the next clock edge, stall_count=0.
- Saturation: force 70000 stall cycles -> stall_count stays at 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control for the five-stage pipeline:
// load-use stall, branch flush, MDU stall FSM, forwarding, stall counter.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_mdu_start,
  input  logic        ex_branch_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mdu_busy,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN,
    MDU_BUSY,
    MDU_DONE
  } state_t;

  localparam bit MDU_MULTI = (MDU_LAT > 1);
  localparam bit MDU_SHORT = (MDU_LAT == 2);
  localparam logic [3:0] CNT_INIT =
    4'(MDU_LAT > 1 ? MDU_LAT - 2 : 0);

  state_t     state;
  state_t     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       mdu_stall;
  logic       load_use;
  logic       br_sel;
  logic       lu_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mdu_stall = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_mdu_start && MDU_MULTI) begin
          mdu_stall = 1'b1;
          cnt_n     = CNT_INIT;
          state_n   = MDU_SHORT ? MDU_DONE : MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        mdu_stall = 1'b1;
        cnt_n     = cnt - 4'd1;
        if (cnt == 4'd1)
          state_n = MDU_DONE;
      end
      MDU_DONE: state_n = RUN;
      default:  state_n = RUN;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) ||
                     (id_uses_rt && (ex_rd == id_rt)));

  // Mutually exclusive selects encode the priority order.
  assign br_sel = ex_branch_taken && !mdu_stall;
  assign lu_sel = load_use && !mdu_stall && !ex_branch_taken;

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    idex_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    unique case (1'b1)
      mdu_stall: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_we      = 1'b0;
        exmem_bubble = 1'b1;
      end
      br_sel: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      lu_sel: begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    fwd_a = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rs)
      fwd_a = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs)
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == ex_rt)
      fwd_b = 2'b10;
    else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rt)
      fwd_b = 2'b01;
  end

  assign mdu_busy = (state == MDU_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= 16'd0;
    else if (!pc_we && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MDU_LAT=4).
// Expected control words are queued at drive time, popped at sample.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd;
  logic [4:0]  mem_rd, wb_rd;
  logic        id_uses_rt, ex_mem_read, ex_mdu_start;
  logic        ex_branch_taken, mem_reg_write, wb_reg_write;
  logic        pc_we, ifid_we, idex_we;
  logic        ifid_flush, idex_flush, exmem_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic        mdu_busy;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [10:0] ctl;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];

  localparam logic [5:0] RUN6 = 6'b111000;
  localparam logic [5:0] LU6  = 6'b001010;
  localparam logic [5:0] BR6  = 6'b111110;
  localparam logic [5:0] MD6  = 6'b000001;

  pipe_hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
    .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mdu_busy(mdu_busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] mk(input logic [5:0] c,
                                     input logic [1:0] fa,
                                     input logic [1:0] fb,
                                     input logic bsy);
    return {c, fa, fb, bsy};
  endfunction

  task automatic push(input string tag, input logic [10:0] c,
                      input logic [15:0] sc);
    exp_t e;
    e.tag = tag;
    e.ctl = c;
    e.sc  = sc;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [10:0] obs;
    e = q.pop_front();
    obs = {pc_we, ifid_we, idex_we, ifid_flush, idex_flush,
           exmem_bubble, fwd_a, fwd_b, mdu_busy};
    total++;
    assert (obs === e.ctl) else begin
      bad++;
      $error("FAIL %s ctl: got %b want %b", e.tag, obs, e.ctl);
    end
    total++;
    assert (stall_count === e.sc) else begin
      bad++;
      $error("FAIL %s stall_count: got %h want %h",
             e.tag, stall_count, e.sc);
    end
  endtask

  task automatic step(input string tag, input logic [10:0] c,
                      input logic [15:0] sc);
    push(tag, c, sc);
    #2;
    check();
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0;
    ex_mem_read = 0; ex_mdu_start = 0; ex_branch_taken = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    step("reset", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd0);
    rst_n = 1'b1;

    @(negedge clk);
    ex_mem_read = 1; ex_rd = 8; id_rs = 8;
    step("lu_rs", mk(LU6, 2'b00, 2'b00, 1'b0), 16'd0);
    @(negedge clk);
    ex_mem_read = 0;
    step("lu_clear", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd1);
    @(negedge clk);
    ex_mem_read = 1; id_rs = 3; id_rt = 8; id_uses_rt = 0;
    step("lu_rt_unused", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd1);
    @(negedge clk);
    id_uses_rt = 1;
    step("lu_rt", mk(LU6, 2'b00, 2'b00, 1'b0), 16'd1);
    @(negedge clk);
    ex_rd = 0; id_rs = 0; id_rt = 0;
    step("lu_r0", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd2);

    @(negedge clk);
    idle();
    mem_rd = 9; wb_rd = 9; mem_reg_write = 1; wb_reg_write = 1;
    ex_rs = 9; ex_rt = 5;
    step("fwd_mem", mk(RUN6, 2'b10, 2'b00, 1'b0), 16'd2);
    @(negedge clk);
    mem_reg_write = 0;
    step("fwd_wb", mk(RUN6, 2'b01, 2'b00, 1'b0), 16'd2);
    @(negedge clk);
    ex_rs = 0;
    step("fwd_rs0", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd2);
    @(negedge clk);
    mem_reg_write = 1; ex_rt = 9;
    step("fwd_b_mem", mk(RUN6, 2'b00, 2'b10, 1'b0), 16'd2);
    @(negedge clk);
    mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    step("fwd_r0", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd2);
    @(negedge clk);
    mem_rd = 4; wb_rd = 9; ex_rt = 9;
    step("fwd_b_wb", mk(RUN6, 2'b00, 2'b01, 1'b0), 16'd2);

    @(negedge clk);
    idle();
    ex_mdu_start = 1;
    step("mdu_entry", mk(MD6, 2'b00, 2'b00, 1'b0), 16'd2);
    @(negedge clk);
    ex_branch_taken = 1;
    step("mdu_busy1", mk(MD6, 2'b00, 2'b00, 1'b1), 16'd3);
    @(negedge clk);
    ex_branch_taken = 0;
    step("mdu_busy2", mk(MD6, 2'b00, 2'b00, 1'b1), 16'd4);
    @(negedge clk);
    step("mdu_done", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd5);
    @(negedge clk);
    ex_mdu_start = 0;
    step("mdu_run", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd5);

    @(negedge clk);
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; ex_branch_taken = 1;
    step("br_lu", mk(BR6, 2'b00, 2'b00, 1'b0), 16'd5);
    @(negedge clk);
    idle();
    step("br_after", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd5);

    @(negedge clk);
    ex_mdu_start = 1;
    step("rst_entry", mk(MD6, 2'b00, 2'b00, 1'b0), 16'd5);
    @(negedge clk);
    step("rst_busy", mk(MD6, 2'b00, 2'b00, 1'b1), 16'd6);
    #1;
    rst_n = 1'b0;
    ex_mdu_start = 0;
    push("rst_async", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd0);
    #1;
    check();
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_after", mk(RUN6, 2'b00, 2'b00, 1'b0), 16'd0);

    @(negedge clk);
    ex_mem_read = 1; ex_rd = 8; id_rs = 8;
    push("sat", mk(LU6, 2'b00, 2'b00, 1'b0), 16'hFFFF);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    #2;
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
